// File: rtl/da_addr_gen.sv
// -----------------------------------------------------------------------------
// da_addr_gen
//   Input stage of a distributed-arithmetic FIR. It accepts one OPSIZE-bit
//   two's-complement sample per handshake and shifts it into an ORDER-tap
//   delay line. It then presents the delay line to the ROM banks as
//   OPSIZE/BAAT bit-slice addresses, one slice per cycle, starting with the
//   LSB slice. The first and last slices are flagged so the downstream
//   shift-accumulator knows when to clear and when to subtract the sign slice.
//
// Ports
//   clk      in   1              rising-edge clock
//   rst_n    in   1              asynchronous active-low reset
//   i_x      in   OPSIZE         input sample
//   i_valid  in   1              i_x is valid
//   i_ready  out  1              a sample is accepted this cycle if i_valid
//   o_addr   out  PARTITION*AW   ROM addresses, partition p at [(p+1)*AW-1 : p*AW]
//   o_valid  out  1              o_addr holds a valid slice
//   o_first  out  1              slice 0 (LSBs) is on o_addr
//   o_last   out  1              slice NCYC-1 (holds the sign bit) is on o_addr
//   d_ready  in   1              downstream consumes the current slice
// -----------------------------------------------------------------------------
module da_addr_gen #(
    parameter int OPSIZE    = 12,
    parameter int ORDER     = 6,
    parameter int BAAT      = 3,
    parameter int PARTITION = 2
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [OPSIZE-1:0]                            i_x,
    input  logic                                         i_valid,
    output logic                                         i_ready,
    output logic [PARTITION*BAAT*(ORDER/PARTITION)-1:0]  o_addr,
    output logic                                         o_valid,
    output logic                                         o_first,
    output logic                                         o_last,
    input  logic                                         d_ready
);

    localparam int TPP  = ORDER / PARTITION;
    localparam int NCYC = OPSIZE / BAAT;
    localparam int AW   = BAAT * TPP;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Parameter sanity checks at elaboration time.
    if ((OPSIZE % BAAT) != 0) begin : g_opsize_chk
        $error("da_addr_gen: OPSIZE (%0d) must be a multiple of BAAT (%0d)", OPSIZE, BAAT);
    end
    if ((ORDER % PARTITION) != 0) begin : g_order_chk
        $error("da_addr_gen: ORDER (%0d) must be a multiple of PARTITION (%0d)", ORDER, PARTITION);
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [OPSIZE-1:0]     tap_q [ORDER];   // delay line, tap 0 is the newest sample
    logic [OPSIZE-1:0]     w_q   [ORDER];   // working copy, shifted right one slice per cycle
    logic                  o_valid_q;
    logic                  o_first_q;
    logic                  o_last_q;

    logic                  i_ready_s;
    logic                  accept_s;
    logic [PARTITION*AW-1:0] addr_s;

    // Handshake: ready when idle, or on the final slice being consumed so the
    // next run begins without a bubble.
    always_comb begin
        i_ready_s = 1'b0;
        accept_s  = 1'b0;
        if (state_q == IDLE) begin
            i_ready_s = 1'b1;
        end else begin
            i_ready_s = o_last_q & d_ready;
        end
        accept_s = i_valid & i_ready_s;
    end

    // Address formation: the low BAAT bits of each working register hold the
    // current slice, so this is pure bit selection.
    always_comb begin
        addr_s = '0;
        for (int p = 0; p < PARTITION; p++) begin
            for (int j = 0; j < BAAT; j++) begin
                for (int k = 0; k < TPP; k++) begin
                    addr_s[p*AW + j*TPP + k] = w_q[p*TPP + k][j];
                end
            end
        end
    end

    // Control FSM with delay line, working registers and registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            o_valid_q <= 1'b0;
            o_first_q <= 1'b0;
            o_last_q  <= 1'b0;
            for (int k = 0; k < ORDER; k++) begin
                tap_q[k] <= '0;
                w_q[k]   <= '0;
            end
        end else if (accept_s) begin
            // New sample: shift the delay line and load the working copy from
            // the post-shift taps. This also covers the back-to-back case on
            // the last slice of a run.
            for (int k = ORDER - 1; k > 0; k--) begin
                tap_q[k] <= tap_q[k-1];
                w_q[k]   <= tap_q[k-1];
            end
            tap_q[0]  <= i_x;
            w_q[0]    <= i_x;
            cnt_q     <= '0;
            state_q   <= RUN;
            o_valid_q <= 1'b1;
            o_first_q <= 1'b1;
            o_last_q  <= (NCYC == 1);
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= IDLE;
                end
                RUN: begin
                    // A stall (d_ready low) holds everything in place.
                    if (d_ready) begin
                        for (int k = 0; k < ORDER; k++) begin
                            w_q[k] <= w_q[k] >> BAAT;
                        end
                        if (cnt_q == LAST_CNT) begin
                            cnt_q     <= '0;
                            state_q   <= IDLE;
                            o_valid_q <= 1'b0;
                            o_first_q <= 1'b0;
                            o_last_q  <= 1'b0;
                        end else begin
                            cnt_q     <= cnt_q + CNT_ONE;
                            o_first_q <= 1'b0;
                            o_last_q  <= ((cnt_q + CNT_ONE) == LAST_CNT);
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    o_valid_q <= 1'b0;
                    o_first_q <= 1'b0;
                    o_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign i_ready = i_ready_s;
    assign o_addr  = addr_s;
    assign o_valid = o_valid_q;
    assign o_first = o_first_q;
    assign o_last  = o_last_q;

endmodule
